// File: rtl/opcode_request_encoder.sv
// ---------------------------------------------------------------------------
// opcode_request_encoder
//
// Collects per-unit request lines into a sticky pending register and hands
// them, one at a time, to the opcode consumer as an encoded opcode on a
// valid/ready output stage. This is the inverse of the 3->8 opcode decoder in
// the MIPS control path.
//
// Parameters
//   WIDTH   number of request lines (power of 2, >= 2)
//   CODE_W  opcode width, log2(WIDTH)
//   RR      0: fixed priority (index 0 highest), 1: round-robin
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_i      request pulses, bit k requests opcode k
//   ready_i    consumer accepts opcode_o this cycle
//   opcode_o   encoded opcode, meaningful only while valid_o = 1
//   valid_o    opcode_o holds a code that has not been accepted yet
//   pending_o  requests collected but not yet moved to the output register
//   ovf_o      sticky flag: a request merged into an already-pending bit
// ---------------------------------------------------------------------------
module opcode_request_encoder #(
    parameter int WIDTH  = 8,
    parameter int CODE_W = 3,
    parameter bit RR     = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  req_i,
    input  logic              ready_i,
    output logic [CODE_W-1:0] opcode_o,
    output logic              valid_o,
    output logic [WIDTH-1:0]  pending_o,
    output logic              ovf_o
);

    // Index of the lowest set bit; zero when the vector is empty (callers
    // only use the result when the vector is non-empty).
    function automatic logic [CODE_W-1:0] lowest_set(input logic [WIDTH-1:0] vec);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [WIDTH-1:0]    pend_r;
    logic [CODE_W-1:0]   code_r;
    logic                valid_r;
    logic [CODE_W-1:0]   last_r;
    logic                ovf_r;

    logic                slot_free_s;
    logic                any_pend_s;
    logic                load_s;
    logic [CODE_W-1:0]   start_s;
    logic [2*WIDTH-1:0]  dbl_s;
    logic [WIDTH-1:0]    rot_s;
    logic [CODE_W-1:0]   sel_s;
    logic [WIDTH-1:0]    clr_s;
    logic [WIDTH-1:0]    pend_next_s;
    logic                merge_s;

    // Selection from the pending register only; round-robin rotates the
    // vector so the search starts just after the last issued index. The
    // CODE_W-bit add wraps naturally because WIDTH is a power of two.
    always_comb begin
        start_s = last_r + CODE_W'(1);
        dbl_s   = {pend_r, pend_r} >> start_s;
        rot_s   = dbl_s[WIDTH-1:0];
        if (RR) begin
            sel_s = start_s + lowest_set(rot_s);
        end else begin
            sel_s = lowest_set(pend_r);
        end
    end

    // Load decision, pending update and overflow detection. A request on the
    // bit being loaded this cycle re-arms that bit (set wins) and is not an
    // overflow, since the earlier request has just been consumed.
    always_comb begin
        slot_free_s = !valid_r || ready_i;
        any_pend_s  = |pend_r;
        load_s      = slot_free_s && any_pend_s;
        if (load_s) begin
            clr_s = {{(WIDTH-1){1'b0}}, 1'b1} << sel_s;
        end else begin
            clr_s = '0;
        end
        pend_next_s = req_i | (pend_r & ~clr_s);
        merge_s     = |(req_i & pend_r & ~clr_s);
    end

    // Pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_next_s;
        end
    end

    // Output stage: code is held untouched until the consumer takes it; an
    // empty free slot drops valid but leaves the old code in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_r  <= '0;
            valid_r <= 1'b0;
        end else if (load_s) begin
            code_r  <= sel_s;
            valid_r <= 1'b1;
        end else if (slot_free_s) begin
            code_r  <= code_r;
            valid_r <= 1'b0;
        end else begin
            code_r  <= code_r;
            valid_r <= valid_r;
        end
    end

    // Round-robin pointer; reset to the top index so the first search starts
    // at index 0. Fixed priority never moves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= CODE_W'(WIDTH - 1);
        end else if (RR && load_s) begin
            last_r <= sel_s;
        end else begin
            last_r <= last_r;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (merge_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign opcode_o  = code_r;
    assign valid_o   = valid_r;
    assign pending_o = pend_r;
    assign ovf_o     = ovf_r;

endmodule
